// File: rtl/cam_pkg.sv
// Shared definitions for the 16-entry CAM and its companion blocks.
//
// Contents:
//   N_ENTRIES - number of CAM entries (width of the match vector)
//   IDX_W     - binary index width, log2(N_ENTRIES)
//   state_e   - two-state controller encoding used by cam_match_reader
package cam_pkg;

  localparam int N_ENTRIES = 16;
  localparam int IDX_W     = $clog2(N_ENTRIES);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage : cam_pkg

// File: rtl/lsb_prio_enc.sv
// Lowest-set-bit priority encoder.
//
// Ports:
//   vec_i  in  W      input vector
//   idx_o  out IDX_W  index of the lowest set bit (0 when vec_i is zero)
//   any_o  out 1      at least one bit of vec_i is set
//   one_o  out 1      exactly one bit of vec_i is set
//   clr_o  out W      vec_i with its lowest set bit cleared
module lsb_prio_enc #(
  parameter int W     = 16,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o,
  output logic             one_o,
  output logic [W-1:0]     clr_o
);

  // Subtracting one borrows through the trailing zeros and flips the lowest
  // set bit, so the AND removes exactly that bit.
  logic [W-1:0] vec_minus_one;

  assign vec_minus_one = vec_i - W'(1);
  assign clr_o         = vec_i & vec_minus_one;
  assign any_o         = |vec_i;
  assign one_o         = any_o && (clr_o == '0);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    idx_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule : lsb_prio_enc

// File: rtl/cam_match_reader.sv
// Read-side companion to the CAM: turns a captured multi-hot match vector into
// a stream of binary entry indices, lowest first, over valid/ready.
//
// Ports:
//   clk          in  1            clock, rising edge
//   rst          in  1            asynchronous active-high reset
//   ena          in  1            enable, gates load acceptance only
//   load         in  1            strobe: capture match_vec
//   match_vec    in  N_ENTRIES    multi-hot match vector from the CAM
//   busy         out 1            captured matches remain to be emitted
//   out_valid    out 1            out_idx/out_last are valid
//   out_ready    in  1            consumer accepts the current index
//   out_idx      out IDX_W        index of the lowest pending match
//   out_last     out 1            current index is the final pending match
//   match_count  out IDX_W+1      popcount of the last accepted vector
//   no_match     out 1            pulse: accepted vector was all-zero
//   load_drop    out 1            pulse: load arrived while busy, discarded
module cam_match_reader
  import cam_pkg::*;
#(
  parameter int N_ENTRIES = cam_pkg::N_ENTRIES,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 load,
  input  logic [N_ENTRIES-1:0] match_vec,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [IDX_W:0]       match_count,
  output logic                 no_match,
  output logic                 load_drop
);

  function automatic logic [IDX_W:0] popcount(input logic [N_ENTRIES-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  state_e                 state_q, state_d;
  logic [N_ENTRIES-1:0]   pending_q, pending_d;
  logic [IDX_W:0]         count_q, count_d;
  logic                   no_match_q, no_match_d;
  logic                   load_drop_q, load_drop_d;

  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
  logic                   enc_one;
  logic [N_ENTRIES-1:0]   enc_clr;
  logic                   emitting;
  logic                   xfer;

  lsb_prio_enc #(
    .W     (N_ENTRIES),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i (pending_q),
    .idx_o (enc_idx),
    .any_o (enc_any),
    .one_o (enc_one),
    .clr_o (enc_clr)
  );

  // Handshake outputs come only from registers, so out_valid never depends
  // combinationally on out_ready.
  assign emitting    = (state_q == EMIT);
  assign busy        = emitting;
  assign out_valid   = emitting;
  assign out_idx     = emitting ? enc_idx : '0;
  assign out_last    = emitting && enc_one;
  assign match_count = count_q;
  assign no_match    = no_match_q;
  assign load_drop   = load_drop_q;

  // pending is never zero while emitting; the any-set guard keeps a transfer
  // from being counted against an empty register.
  assign xfer = emitting && out_ready && enc_any;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    count_d     = count_q;
    no_match_d  = 1'b0;
    load_drop_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (load && ena) begin
          if (match_vec != '0) begin
            pending_d = match_vec;
            count_d   = popcount(match_vec);
            state_d   = EMIT;
          end else begin
            count_d    = '0;
            no_match_d = 1'b1;
          end
        end
      end

      EMIT: begin
        // A load while busy is discarded regardless of ena, including on the
        // cycle of the final transfer.
        if (load) load_drop_d = 1'b1;
        if (xfer) begin
          pending_d = enc_clr;
          if (enc_one) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      count_q     <= '0;
      no_match_q  <= 1'b0;
      load_drop_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge value of every other register.
      state_q     <= state_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
      no_match_q  <= no_match_d;
      load_drop_q <= load_drop_d;
    end
  end

endmodule : cam_match_reader

// File: tb/tb_cam_match_reader.sv
// Self-checking bench for cam_match_reader. A queue of expected indices is
// the reference: an accepted vector is expanded into its set-bit positions in
// ascending order, and each accepted transfer pops the head.
module tb_cam_match_reader;
  import cam_pkg::*;

  localparam int NE = cam_pkg::N_ENTRIES;
  localparam int IW = cam_pkg::IDX_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          ena;
  logic          load;
  logic [NE-1:0] match_vec;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic [IW:0]   match_count;
  logic          no_match;
  logic          load_drop;

  cam_match_reader dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .load        (load),
    .match_vec   (match_vec),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .match_count (match_count),
    .no_match    (no_match),
    .load_drop   (load_drop)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int   m_q[$];
  int   m_cnt  = 0;
  bit   m_nm   = 1'b0;
  bit   m_drop = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    bit v;
    v = (m_q.size() > 0);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".busy"},  32'(busy), 32'(v));
    check({tag, ".last"},  32'(out_last), 32'(v && m_q.size() == 1));
    if (v) check({tag, ".idx"}, 32'(out_idx), 32'(m_q[0]));
    check({tag, ".count"},    32'(match_count), 32'(m_cnt));
    check({tag, ".no_match"}, 32'(no_match), 32'(m_nm));
    check({tag, ".drop"},     32'(load_drop), 32'(m_drop));
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic drive(input string tag, input bit l, input logic [NE-1:0] v,
                       input bit e, input bit r);
    int c;
    load = l; match_vec = v; ena = e; out_ready = r;
    m_nm = 1'b0;
    m_drop = 1'b0;
    if (m_q.size() > 0) begin
      if (l) m_drop = 1'b1;
      if (r) void'(m_q.pop_front());
    end else if (l && e) begin
      c = 0;
      for (int i = 0; i < NE; i++) begin
        if (v[i]) begin
          m_q.push_back(i);
          c++;
        end
      end
      m_cnt = c;
      if (c == 0) m_nm = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt  = 0;
    m_nm   = 1'b0;
    m_drop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; load = 1'b0; match_vec = '0; out_ready = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    check("reset.idx", 32'(out_idx), 32'd0);
    #1 rst = 1'b0;

    // All-zero vector: no_match pulse, nothing emitted.
    drive("zero.load", 1'b1, 16'h0000, 1'b1, 1'b1);
    drive("zero.after", 1'b0, 16'h0000, 1'b1, 1'b1);
    drive("zero.idle", 1'b0, 16'h0000, 1'b1, 1'b1);

    // load with ena low is ignored.
    drive("noena", 1'b1, 16'h00FF, 1'b0, 1'b1);
    drive("noena.after", 1'b0, 16'h0000, 1'b0, 1'b1);

    // 8421 with ready tied high: 0,5,10,15 back to back.
    drive("8421.load", 1'b1, 16'h8421, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) drive("8421.stream", 1'b0, 16'h0000, 1'b1, 1'b1);

    // 0006 with backpressure: index 1 held for three cycles.
    drive("0006.load", 1'b1, 16'h0006, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("0006.hold", 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("0006.stream", 1'b0, 16'h0000, 1'b1, 1'b1);

    // All-ones vector with random ready; count needs the extra bit.
    drive("ffff.load", 1'b1, 16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 200 && m_q.size() > 0; i++)
      drive("ffff.stream", 1'b0, 16'h0000, 1'b1, 1'($urandom_range(0, 1)));
    drive("ffff.done", 1'b0, 16'h0000, 1'b1, 1'b1);

    // Load during EMIT is dropped and does not disturb the stream.
    drive("0030.load", 1'b1, 16'h0030, 1'b1, 1'b0);
    drive("0030.drop", 1'b1, 16'h0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive("0030.stream", 1'b0, 16'h0000, 1'b1, 1'b1);

    // Load on the cycle of the final transfer is dropped.
    drive("last.load", 1'b1, 16'h0001, 1'b1, 1'b0);
    drive("last.xfer_load", 1'b1, 16'h0080, 1'b1, 1'b1);
    drive("last.idle", 1'b0, 16'h0000, 1'b1, 1'b1);

    // Mid-stream asynchronous reset.
    drive("0f00.load", 1'b1, 16'h0F00, 1'b1, 1'b0);
    drive("0f00.xfer", 1'b0, 16'h0000, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    check("async_rst.idx", 32'(out_idx), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int i = 0; i < 3; i++) drive("post_rst.idle", 1'b0, 16'h0000, 1'b1, 1'b1);
    drive("0002.load", 1'b1, 16'h0002, 1'b1, 1'b1);
    drive("0002.done", 1'b0, 16'h0000, 1'b1, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit           l, e, r;
      logic [NE-1:0] v;
      l = ($urandom_range(0, 5) == 0);
      e = ($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 5) == 0) ? '0 : NE'($urandom);
      drive("random", l, v, e, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cam_match_reader
